// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI bridge: FSM state enums,
// fixed AXI field encodings, default transaction IDs and the fetch-buffer entry.
package axi_bridge_pkg;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int DEF_INST_ID = 0;
  localparam int DEF_DATA_ID = 1;

  typedef struct packed {
    logic        vld;
    logic [63:0] tag;
    logic [63:0] data;
  } ibuf_ent_t;

  function automatic logic [63:0] align8(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// Single 64-bit AXI4 master port (all five channels) used by cpu_axi_bridge.
interface cpu_axi_bridge_if #(parameter int AXI_ID_W = 4);
  logic                arvalid, arready;
  logic [63:0]         araddr;
  logic [AXI_ID_W-1:0] arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid, rready;
  logic [63:0]         rdata;
  logic [AXI_ID_W-1:0] rid;
  logic [1:0]          rresp;
  logic                rlast;

  logic                awvalid, awready;
  logic [63:0]         awaddr;
  logic [AXI_ID_W-1:0] awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid, wready;
  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                wlast;

  logic                bvalid, bready;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rid, rresp, rlast, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rid, rresp, rlast, input rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready
  );
endinterface

// File: rtl/axi_bridge_ibuf.sv
// One-entry fetch buffer {valid, aligned tag, data}; refilled by every fetch
// return, invalidated when a store to the tagged doubleword completes.
module axi_bridge_ibuf
  import axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] lookup_addr,
  output logic        hit,
  output logic [63:0] hit_data,
  input  logic        fill,
  input  logic [63:0] fill_addr,
  input  logic [63:0] fill_data,
  input  logic        inval,
  input  logic [63:0] inval_addr
);
  ibuf_ent_t ent;
  logic [63:0] cmp_tag;

  assign hit      = ent.vld && (ent.tag == align8(lookup_addr));
  assign hit_data = ent.data;
  // A same-cycle refill of the stored-to line must not survive the invalidate.
  assign cmp_tag  = fill ? align8(fill_addr) : ent.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else begin
      if (fill) begin
        ent.vld  <= 1'b1;
        ent.tag  <= align8(fill_addr);
        ent.data <= fill_data;
      end
      if (inval && cmp_tag == align8(inval_addr)) ent.vld <= 1'b0;
    end
  end
endmodule

// File: rtl/cpu_axi_bridge.sv
// SRAM-style fetch/load/store to single-beat AXI4 bridge with core stall.
// Optional fetch buffer enabled by defining BRIDGE_IBUF_EN.
module cpu_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int INST_ID  = DEF_INST_ID,
  parameter int DATA_ID  = DEF_DATA_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_sram_en,
  input  logic [63:0] inst_sram_addr,
  output logic [63:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        stallreq_axi,
  output logic        axi_err,
  cpu_axi_bridge_if.master axi
);
  localparam logic [AXI_ID_W-1:0] IID = AXI_ID_W'(INST_ID);
  localparam logic [AXI_ID_W-1:0] DID = AXI_ID_W'(DATA_ID);

  logic inst_done, dload_done, dstore_done;
  logic fetch_pend, load_pend, store_pend;
  logic ibuf_hit, ibuf_take;
  logic [63:0] ibuf_data;

  assign stallreq_axi = (inst_sram_en & ~inst_done) |
                        (data_sram_en & ~(dload_done | dstore_done));
  assign fetch_pend = inst_sram_en & ~inst_done;
  assign load_pend  = data_sram_en & ~(|data_sram_we) & ~dload_done;
  assign store_pend = data_sram_en & (|data_sram_we) & ~dstore_done;
  assign ibuf_take  = fetch_pend & ibuf_hit;

  // ---------------- read FSM ----------------
  rd_state_e rd_state, rd_next;
  logic rd_take_load, rd_take_fetch, r_fire, r_inst, r_data;
  logic [63:0] araddr_q;
  logic [AXI_ID_W-1:0] arid_q;

  always_ff @(posedge clk) begin
    if (rst_n) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next       = rd_state;
    rd_take_load  = 1'b0;
    rd_take_fetch = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (load_pend) begin
          rd_next      = R_AR;
          rd_take_load = 1'b1;
        end else if (fetch_pend && !ibuf_hit) begin
          rd_next       = R_AR;
          rd_take_fetch = 1'b1;
        end
      end
      R_AR:    if (axi.arready) rd_next = R_WAIT;
      R_WAIT:  if (axi.rvalid)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      araddr_q <= '0;
      arid_q   <= '0;
    end else if (rd_take_load) begin
      araddr_q <= align8(data_sram_addr);
      arid_q   <= DID;
    end else if (rd_take_fetch) begin
      araddr_q <= align8(inst_sram_addr);
      arid_q   <= IID;
    end
  end

  assign r_fire = (rd_state == R_WAIT) & axi.rvalid;
  assign r_data = r_fire & (arid_q == DID);
  assign r_inst = r_fire & (arid_q != DID);

  assign axi.arvalid = (rd_state == R_AR);
  assign axi.araddr  = araddr_q;
  assign axi.arid    = arid_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = (rd_state == R_WAIT);

  // ---------------- write FSM ----------------
  wr_state_e wr_state, wr_next;
  logic aw_pend, w_pend, aw_left, w_left, b_fire;
  logic [63:0] awaddr_q, wdata_q;
  logic [7:0]  wstrb_q;

  // Each valid drops on its own handshake; W_RESP waits for both.
  assign aw_left = aw_pend & ~axi.awready;
  assign w_left  = w_pend  & ~axi.wready;
  assign b_fire  = (wr_state == W_RESP) & axi.bvalid;

  always_ff @(posedge clk) begin
    if (rst_n) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (store_pend)          wr_next = W_ADDR;
      W_ADDR:  if (!aw_left && !w_left) wr_next = W_RESP;
      W_RESP:  if (axi.bvalid)          wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (wr_state == W_IDLE && store_pend) begin
      aw_pend  <= 1'b1;
      w_pend   <= 1'b1;
      awaddr_q <= align8(data_sram_addr);
      wdata_q  <= data_sram_wdata;
      wstrb_q  <= data_sram_we;
    end else if (wr_state == W_ADDR) begin
      aw_pend <= aw_left;
      w_pend  <= w_left;
    end
  end

  assign axi.awvalid = aw_pend;
  assign axi.awaddr  = awaddr_q;
  assign axi.awid    = DID;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = AXI_SIZE_8B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = w_pend;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = (wr_state == W_RESP);

  // ---------------- completion / data return ----------------
  // Once the stall drops the pipeline has advanced, so every flag rearms.
  always_ff @(posedge clk) begin
    if (rst_n || !stallreq_axi) begin
      inst_done   <= 1'b0;
      dload_done  <= 1'b0;
      dstore_done <= 1'b0;
    end else begin
      if (r_inst || ibuf_take) inst_done   <= 1'b1;
      if (r_data)              dload_done  <= 1'b1;
      if (b_fire)              dstore_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (r_inst)         inst_sram_rdata <= axi.rdata;
      else if (ibuf_take) inst_sram_rdata <= ibuf_data;
      if (r_data)         data_sram_rdata <= axi.rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) axi_err <= 1'b0;
    else if ((r_fire && axi.rresp != AXI_RESP_OKAY) ||
             (b_fire && axi.bresp != AXI_RESP_OKAY)) axi_err <= 1'b1;
  end

`ifdef BRIDGE_IBUF_EN
  axi_bridge_ibuf u_ibuf (
    .clk        (clk),
    .rst        (rst_n),
    .lookup_addr(inst_sram_addr),
    .hit        (ibuf_hit),
    .hit_data   (ibuf_data),
    .fill       (r_inst),
    .fill_addr  (araddr_q),
    .fill_data  (axi.rdata),
    .inval      (b_fire),
    .inval_addr (awaddr_q)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

endmodule
